// File: rtl/im2col_spc_dma_launcher.sv
// im2col descriptor FIFO consumer: pops descriptors, launches them on the DMA channel, counts completions.
// Optional build macro IM2COL_SPC_EMPTY_SKIP_EN: fully padded descriptors are retired without a DMA request.
package im2col_spc_pkg;
   typedef struct packed {
      logic [31:0] input_ptr;
      logic [31:0] output_ptr;
      logic [15:0] size_du_d1;
      logic [15:0] size_du_d2;
   } dma_if_t;
endpackage

module im2col_spc_dma_launcher
   import im2col_spc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             fifo_empty_i,
   input  dma_if_t          fifo_output_i,
   output logic             fifo_pop_o,
   input  logic             im2col_param_done_i,
   output logic             dma_req_o,
   output dma_if_t          dma_cfg_o,
   input  logic             dma_ack_i,
   input  logic             dma_done_i,
   output logic [CNT_W-1:0] transfers_o,
   output logic             im2col_done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LAUNCH, S_WAIT_DONE, S_FINISH
   } state_e;

   state_e           state_q, state_d;
   dma_if_t          cfg_q;
   logic             req_q;
   logic [CNT_W-1:0] cnt_q;
   logic             load, cnt_inc, cnt_clr, skip;

`ifdef IM2COL_SPC_EMPTY_SKIP_EN
   assign skip = (fifo_output_i.size_du_d1 == '0) || (fifo_output_i.size_du_d2 == '0);
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      fifo_pop_o    = 1'b0;
      im2col_done_o = 1'b0;
      load          = 1'b0;
      cnt_inc       = 1'b0;
      cnt_clr       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A queued descriptor always beats completion.
            if (!fifo_empty_i)
               state_d = S_POP;
            else if (im2col_param_done_i && (cnt_q != '0))
               state_d = S_FINISH;
         end
         S_POP: begin
            if (!fifo_empty_i) begin
               fifo_pop_o = 1'b1;
               load       = 1'b1;
               if (skip) begin
                  cnt_inc = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_LAUNCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            if (dma_ack_i) begin
               if (dma_done_i) begin
                  cnt_inc = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_DONE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (dma_done_i) begin
               cnt_inc = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_FINISH: begin
            im2col_done_o = 1'b1;
            cnt_clr       = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         cfg_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         // Request is a registered copy of "next state is LAUNCH" so it drops on the ack edge.
         req_q   <= (state_d == S_LAUNCH);
         if (load)
            cfg_q <= fifo_output_i;
         if (cnt_clr)
            cnt_q <= '0;
         else if (cnt_inc && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign dma_req_o   = req_q;
   assign dma_cfg_o   = cfg_q;
   assign transfers_o = cnt_q;

endmodule
